// File: rtl/arb_requester_pkg.sv
// ============================================================================
// arb_requester_pkg : shared types and defaults for the arbiter requester port
// Revision: 1.0
// ============================================================================
`default_nettype none

package arb_requester_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_XFER = 2'b10,
        S_REL  = 2'b11
    } state_e;

endpackage

`default_nettype wire

// File: rtl/arb_requester_sync_fifo.sv
// ============================================================================
// sync_fifo : first-word-fall-through FIFO with occupancy count
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Enables arrive already qualified by the owner; pointers wrap naturally
    // because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en_i, rd_en_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/arb_requester.sv
// ============================================================================
// arb_requester : packet-buffering requester port for the round-robin arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_requester
    import arb_requester_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic              in_wr_valid,
    input  logic [DATA_W-1:0] in_wr_data,
    input  logic              in_wr_last,
    output logic              out_wr_ready,
    output logic              out_request,
    input  logic              in_grant,
    output logic              out_bus_valid,
    output logic [DATA_W-1:0] out_bus_data,
    output logic              out_bus_last,
    input  logic              in_bus_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_error
);

    state_e           state_q;
    logic             request_q;
    logic             bus_valid_q;
    logic             error_q;
    logic [CNT_W-1:0] pkt_cnt_q;

    logic [DATA_W:0]  head;
    logic             head_last;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             rd_fire;
    logic             wr_fire;
    logic [CNT_W-1:0] count_d;

    assign head_last = head[DATA_W];
    assign rd_fire   = bus_valid_q & in_bus_ready;
    // A full FIFO still takes a write in the same cycle the head is popped.
    assign wr_fire   = in_wr_valid & (~fifo_full | rd_fire);
    assign count_d   = fifo_count + CNT_W'(wr_fire) - CNT_W'(rd_fire);

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i     (in_clk),
        .rst_ni    (in_reset),
        .wr_en_i   (wr_fire),
        .wr_data_i ({in_wr_last, in_wr_data}),
        .rd_en_i   (rd_fire),
        .head_o    (head),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q     <= S_IDLE;
            request_q   <= 1'b0;
            bus_valid_q <= 1'b0;
            error_q     <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            case ({wr_fire & in_wr_last, rd_fire & head_last})
                2'b10:   pkt_cnt_q <= pkt_cnt_q + 1'b1;
                2'b01:   pkt_cnt_q <= pkt_cnt_q - 1'b1;
                default: pkt_cnt_q <= pkt_cnt_q;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (pkt_cnt_q != '0) begin
                        state_q   <= S_REQ;
                        request_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (in_grant) begin
                        state_q     <= S_XFER;
                        bus_valid_q <= (count_d != '0);
                    end
                end
                S_XFER: begin
                    if (rd_fire && head_last) begin
                        state_q     <= S_REL;
                        request_q   <= 1'b0;
                        bus_valid_q <= 1'b0;
                    end else if (!in_grant) begin
                        // Unsent words of this packet stay queued for the next tenure.
                        state_q     <= S_REL;
                        request_q   <= 1'b0;
                        bus_valid_q <= 1'b0;
                        error_q     <= 1'b1;
                    end else begin
                        bus_valid_q <= (count_d != '0);
                    end
                end
                S_REL: begin
                    if (!in_grant) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    request_q   <= 1'b0;
                    bus_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_wr_ready  = ~fifo_full;
    assign out_request   = request_q;
    assign out_bus_valid = bus_valid_q;
    assign out_bus_data  = head[DATA_W-1:0];
    assign out_bus_last  = bus_valid_q & head_last;
    assign out_count     = fifo_count;
    assign out_error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_requester.sv
// ============================================================================
// tb_arb_requester : scoreboard bench for arb_requester with an arbiter model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_arb_requester;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              in_clk       = 1'b0;
    logic              in_reset     = 1'b0;
    logic              in_wr_valid  = 1'b0;
    logic [DATA_W-1:0] in_wr_data   = '0;
    logic              in_wr_last   = 1'b0;
    logic              in_grant     = 1'b0;
    logic              in_bus_ready = 1'b0;
    logic              out_wr_ready;
    logic              out_request;
    logic              out_bus_valid;
    logic [DATA_W-1:0] out_bus_data;
    logic              out_bus_last;
    logic [CNT_W-1:0]  out_count;
    logic              out_error;

    arb_requester #(.DATA_W(DATA_W), .DEPTH(8), .CNT_W(CNT_W)) dut (
        .in_clk        (in_clk),
        .in_reset      (in_reset),
        .in_wr_valid   (in_wr_valid),
        .in_wr_data    (in_wr_data),
        .in_wr_last    (in_wr_last),
        .out_wr_ready  (out_wr_ready),
        .out_request   (out_request),
        .in_grant      (in_grant),
        .out_bus_valid (out_bus_valid),
        .out_bus_data  (out_bus_data),
        .out_bus_last  (out_bus_last),
        .in_bus_ready  (in_bus_ready),
        .out_count     (out_count),
        .out_error     (out_error)
    );

    always #5 in_clk = ~in_clk;

    int              n_vec  = 0;
    int              n_err  = 0;
    int              n_pops = 0;
    logic [DATA_W:0] sb_q[$];
    bit              hold_grant = 1'b0;
    bit              drop_grant = 1'b0;
    int              gcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Arbiter model: grants two cycles after seeing the request, withdraws
    // one cycle after the request falls.
    always @(negedge in_clk) begin
        #1;
        if (!in_reset) begin
            in_grant = 1'b0;
            gcnt     = 0;
        end else if (in_grant) begin
            if (drop_grant || (!out_request && !hold_grant)) in_grant = 1'b0;
        end else if (out_request && !drop_grant) begin
            gcnt++;
            if (gcnt >= 2) begin
                in_grant = 1'b1;
                gcnt     = 0;
            end
        end else begin
            gcnt = 0;
        end
    end

    // Monitor: pops the scoreboard on every accepted beat.
    logic [DATA_W:0] prev_beat  = '0;
    bit              prev_stall = 1'b0;
    bit              prev_req   = 1'b0;
    always @(negedge in_clk) begin
        #2;
        if (in_reset) begin
            if (prev_stall)
                check("stall_hold", {out_bus_valid, out_bus_last, out_bus_data}, {1'b1, prev_beat});
            if (out_request && !prev_req)
                check("req_while_grant", in_grant, 1'b0);
            if (out_bus_valid && in_bus_ready) begin
                check("beat_granted", in_grant, 1'b1);
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL beat_unexpected: got %0h, expected no beat", {out_bus_last, out_bus_data});
                end else begin
                    check("beat", {out_bus_last, out_bus_data}, sb_q.pop_front());
                end
                n_pops++;
            end
            prev_stall = out_bus_valid && !in_bus_ready && in_grant;
            prev_beat  = {out_bus_last, out_bus_data};
            prev_req   = out_request;
        end else begin
            prev_stall = 1'b0;
            prev_req   = 1'b0;
        end
    end

    task automatic push(input logic [DATA_W-1:0] d, input logic l);
        in_wr_valid = 1'b1;
        in_wr_data  = d;
        in_wr_last  = l;
        if (out_wr_ready) sb_q.push_back({l, d});
        @(negedge in_clk);
        in_wr_valid = 1'b0;
        in_wr_last  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50 && !out_bus_valid; i++) @(negedge in_clk);
        check(name, out_bus_valid, 1'b1);
    endtask

    task automatic wait_quiet(input string name);
        for (int i = 0; i < 100; i++) begin
            if (out_count == 0 && !out_request && !in_grant && !out_bus_valid) break;
            @(negedge in_clk);
        end
        check(name, {out_count, out_request, in_grant, out_bus_valid}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int p0;
        bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        repeat (3) @(negedge in_clk);
        check("rst_outputs", {out_request, out_bus_valid, out_bus_last, out_error, out_bus_data}, '0);
        check("rst_count", out_count, 4'd0);
        check("rst_wr_ready", out_wr_ready, 1'b1);
        in_reset = 1'b1;
        @(negedge in_clk);

        // 1: single 3-word packet
        in_bus_ready = 1'b1;
        push(32'hA1, 1'b0);
        push(32'hA2, 1'b0);
        push(32'hA3, 1'b1);
        check("t1_req_before", out_request, 1'b0);
        @(negedge in_clk);
        check("t1_req_rise", out_request, 1'b1);
        wait_valid("t1_valid");
        p0 = n_pops;
        repeat (3) @(negedge in_clk);
        check("t1_beats_consecutive", n_pops - p0, 3);
        check("t1_req_drop", {out_request, out_bus_valid}, 2'b00);
        wait_quiet("t1_quiet");

        // 2: second packet queued during XFER, grant held after release
        hold_grant = 1'b1;
        push(32'h2001, 1'b0);
        push(32'h2002, 1'b1);
        wait_valid("t2_valid");
        push(32'h2101, 1'b0);
        push(32'h2102, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t2_req_low_while_granted", {out_request, out_bus_valid, in_grant}, 3'b001);
            @(negedge in_clk);
        end
        hold_grant = 1'b0;
        wait_quiet("t2_quiet");

        // 3: ready stalls during a 4-word packet
        in_bus_ready = 1'b0;
        push(32'h3001, 1'b0);
        push(32'h3002, 1'b0);
        push(32'h3003, 1'b0);
        push(32'h3004, 1'b1);
        wait_valid("t3_valid");
        p0 = n_pops;
        for (int i = 0; i < 5; i++) begin
            in_bus_ready = pat[i];
            @(negedge in_clk);
        end
        in_bus_ready = 1'b1;
        wait_quiet("t3_quiet");
        check("t3_beat_count", n_pops - p0, 4);

        // 4: full FIFO, dropped write, simultaneous pop and push
        in_bus_ready = 1'b0;
        for (int i = 1; i <= 7; i++) push(32'h4000 + i, 1'b0);
        push(32'h4008, 1'b1);
        check("t4_full_count", out_count, 4'd8);
        check("t4_full_ready", out_wr_ready, 1'b0);
        in_wr_valid = 1'b1;
        in_wr_data  = 32'hDEAD;
        in_wr_last  = 1'b1;
        @(negedge in_clk);
        in_wr_valid = 1'b0;
        in_wr_last  = 1'b0;
        check("t4_drop_count", out_count, 4'd8);
        wait_valid("t4_valid");
        in_bus_ready = 1'b1;
        in_wr_valid  = 1'b1;
        in_wr_data   = 32'h4100;
        in_wr_last   = 1'b1;
        sb_q.push_back({1'b1, 32'h4100});
        @(negedge in_clk);
        in_wr_valid  = 1'b0;
        in_wr_last   = 1'b0;
        in_bus_ready = 1'b0;
        check("t4_rw_full_count", out_count, 4'd8);
        in_bus_ready = 1'b1;
        wait_quiet("t4_quiet");

        // 5: grant lost after first beat
        in_bus_ready = 1'b0;
        push(32'h5001, 1'b0);
        push(32'h5002, 1'b0);
        push(32'h5003, 1'b1);
        wait_valid("t5_valid");
        p0 = n_pops;
        in_bus_ready = 1'b1;
        @(negedge in_clk);
        in_bus_ready = 1'b0;
        drop_grant   = 1'b1;
        @(negedge in_clk);
        check("t5_error_set", {out_error, out_bus_valid, out_request}, 3'b100);
        drop_grant   = 1'b0;
        in_bus_ready = 1'b1;
        wait_quiet("t5_quiet");
        check("t5_error_sticky", out_error, 1'b1);
        check("t5_beat_count", n_pops - p0, 3);

        // 6: reset mid-XFER
        in_bus_ready = 1'b0;
        push(32'h6001, 1'b0);
        push(32'h6002, 1'b0);
        push(32'h6003, 1'b1);
        wait_valid("t6_valid");
        #3;
        in_reset = 1'b0;
        #1;
        check("t6_rst_outputs", {out_request, out_bus_valid, out_bus_last, out_error, out_bus_data}, '0);
        check("t6_rst_count", out_count, 4'd0);
        check("t6_rst_wr_ready", out_wr_ready, 1'b1);
        sb_q.delete();
        @(negedge in_clk);
        #3;
        in_reset = 1'b1;
        @(negedge in_clk);
        in_bus_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t6_no_req_after_reset", out_request, 1'b0);
            @(negedge in_clk);
        end
        p0 = n_pops;
        push(32'h6101, 1'b1);
        wait_quiet("t6_quiet");
        check("t6_new_packet", n_pops - p0, 1);

        check("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
